// File: rtl/mem_initiator.sv
// Initiator end of the RV32I memory port: one load/store per handshake, registered mem_* drive.
// Define LSU_ALIGN_CHECK_EN to reject misaligned or illegal commands with rsp_error.
module mem_initiator #(
  parameter logic [2:0] RESET_FUNCT3 = 3'b010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  output logic        mem_write,
  output logic [2:0]  mem_funct3,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic [31:0] mem_read_address,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state_q, state_d;
  logic        cmd_write_q, cmd_write_d;
  logic        req_ready_q, req_ready_d;
  logic        mem_write_q, mem_write_d;
  logic [2:0]  mem_funct3_q, mem_funct3_d;
  logic [31:0] mem_waddr_q, mem_waddr_d;
  logic [31:0] mem_raddr_q, mem_raddr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        reject_c;

`ifdef LSU_ALIGN_CHECK_EN
  // Misaligned word/half, reserved funct3 encodings, or unsigned-style store encodings.
  always_comb begin
    reject_c = 1'b0;
    if ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00)) reject_c = 1'b1;
    if ((req_funct3[1:0] == 2'b01) && req_addr[0])              reject_c = 1'b1;
    if ((req_funct3 == 3'b011) || (req_funct3 == 3'b110) || (req_funct3 == 3'b111))
      reject_c = 1'b1;
    if (req_write && req_funct3[2])                              reject_c = 1'b1;
  end
`else
  assign reject_c = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    cmd_write_d  = cmd_write_q;
    mem_write_d  = 1'b0;
    mem_funct3_d = mem_funct3_q;
    mem_waddr_d  = mem_waddr_q;
    mem_raddr_d  = mem_raddr_q;
    mem_wdata_d  = mem_wdata_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_error_d  = rsp_error_q;
    rsp_rdata_d  = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cmd_write_d  = req_write;
          mem_funct3_d = req_funct3;
          mem_waddr_d  = req_addr;
          mem_raddr_d  = req_addr;
          mem_wdata_d  = req_wdata;
          rsp_rdata_d  = 32'h0;
          if (reject_c) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_write_d = req_write;
            rsp_error_d = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (cmd_write_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        rsp_rdata_d = mem_read_data;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d      = IDLE;
          rsp_valid_d  = 1'b0;
          rsp_error_d  = 1'b0;
          mem_funct3_d = RESET_FUNCT3;
        end
      end
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cmd_write_q  <= 1'b0;
      req_ready_q  <= 1'b1;
      mem_write_q  <= 1'b0;
      mem_funct3_q <= RESET_FUNCT3;
      mem_waddr_q  <= 32'h0;
      mem_raddr_q  <= 32'h0;
      mem_wdata_q  <= 32'h0;
      rsp_valid_q  <= 1'b0;
      rsp_error_q  <= 1'b0;
      rsp_rdata_q  <= 32'h0;
    end else begin
      state_q      <= state_d;
      cmd_write_q  <= cmd_write_d;
      req_ready_q  <= req_ready_d;
      mem_write_q  <= mem_write_d;
      mem_funct3_q <= mem_funct3_d;
      mem_waddr_q  <= mem_waddr_d;
      mem_raddr_q  <= mem_raddr_d;
      mem_wdata_q  <= mem_wdata_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_error_q  <= rsp_error_d;
      rsp_rdata_q  <= rsp_rdata_d;
    end
  end

  assign req_ready         = req_ready_q;
  assign rsp_valid         = rsp_valid_q;
  assign rsp_rdata         = rsp_rdata_q;
  assign rsp_error         = rsp_error_q;
  assign mem_write         = mem_write_q;
  assign mem_funct3        = mem_funct3_q;
  assign mem_write_address = mem_waddr_q;
  assign mem_write_data    = mem_wdata_q;
  assign mem_read_address  = mem_raddr_q;

endmodule

// File: tb/tb_mem_initiator.sv
// Directed bench for mem_initiator with a small byte-addressed memory behind the port.
module tb_mem_initiator;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [31:0] rsp_rdata;
  logic        mem_write;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_write_address, mem_write_data, mem_read_address;
  logic [31:0] mem_read_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_initiator dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .mem_write(mem_write), .mem_funct3(mem_funct3),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_address(mem_read_address), .mem_read_data(mem_read_data)
  );

  // Memory: byte/half/word stores, loads formatted from sampled funct3, one-cycle read latency.
  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    logic [9:0]  a;
    logic [31:0] w;
    if (mem_write) begin
      a = mem_write_address[9:0];
      case (mem_funct3[1:0])
        2'b00: mem[a] <= mem_write_data[7:0];
        2'b01: begin
          mem[{a[9:1], 1'b0}] <= mem_write_data[7:0];
          mem[{a[9:1], 1'b1}] <= mem_write_data[15:8];
        end
        default: begin
          mem[{a[9:2], 2'b00}] <= mem_write_data[7:0];
          mem[{a[9:2], 2'b01}] <= mem_write_data[15:8];
          mem[{a[9:2], 2'b10}] <= mem_write_data[23:16];
          mem[{a[9:2], 2'b11}] <= mem_write_data[31:24];
        end
      endcase
    end
    a = mem_read_address[9:0];
    case (mem_funct3)
      3'b000: w = {{24{mem[a][7]}}, mem[a]};
      3'b100: w = {24'h0, mem[a]};
      3'b001: w = {{16{mem[{a[9:1], 1'b1}][7]}}, mem[{a[9:1], 1'b1}], mem[{a[9:1], 1'b0}]};
      3'b101: w = {16'h0, mem[{a[9:1], 1'b1}], mem[{a[9:1], 1'b0}]};
      default: w = {mem[{a[9:2], 2'b11}], mem[{a[9:2], 2'b10}],
                    mem[{a[9:2], 2'b01}], mem[{a[9:2], 2'b00}]};
    endcase
    mem_read_data <= w;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One command; hold = cycles rsp_ready stays low in RESP while a bogus request is offered.
  task automatic do_cmd(input string tag, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_er,
                        input int exp_lat, input int hold);
    int lat;
    int wcnt;
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    wcnt = 0;
    if (!exp_er) begin
      chk({tag, "_issue_f3"}, 32'(mem_funct3), 32'(f3));
      chk({tag, "_issue_addr"}, wr ? mem_write_address : mem_read_address, a);
    end
    while (!rsp_valid && lat < 20) begin
      wcnt += 32'(mem_write);
      @(posedge clk); #1;
      lat++;
    end
    wcnt += 32'(mem_write);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_rdata"}, rsp_rdata, exp_rd);
    chk({tag, "_error"}, 32'(rsp_error), 32'(exp_er));
    chk({tag, "_wr_cycles"}, 32'(wcnt), (wr && !exp_er) ? 32'd1 : 32'd0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b010;
      req_addr = 32'h0000_0200; req_wdata = 32'h1111_1111;
      @(posedge clk); #1;
      chk({tag, "_stall_valid"}, 32'(rsp_valid), 32'd1);
      chk({tag, "_stall_rdata"}, rsp_rdata, exp_rd);
      chk({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_stall_mw"}, 32'(mem_write), 32'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_done_f3"}, 32'(mem_funct3), 32'd2);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
    chk({tag, "_mem_write"}, 32'(mem_write), 32'd0);
    chk({tag, "_mem_funct3"}, 32'(mem_funct3), 32'd2);
    chk({tag, "_waddr"}, mem_write_address, 32'h0);
    chk({tag, "_raddr"}, mem_read_address, 32'h0);
    chk({tag, "_wdata"}, mem_write_data, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    do_cmd("sw",  1'b1, 3'b010, 32'h100, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 0);
    do_cmd("lw",  1'b0, 3'b010, 32'h100, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0);
    do_cmd("sw0", 1'b1, 3'b010, 32'h100, 32'h0,         32'h0,         1'b0, 2, 0);
    do_cmd("sb",  1'b1, 3'b000, 32'h101, 32'h0000_0080, 32'h0,         1'b0, 2, 0);
    do_cmd("lb",  1'b0, 3'b000, 32'h101, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 0);
    do_cmd("lbu", 1'b0, 3'b100, 32'h101, 32'h0,         32'h0000_0080, 1'b0, 3, 0);
    do_cmd("lhu", 1'b0, 3'b101, 32'h100, 32'h0,         32'h0000_8000, 1'b0, 3, 0);
`ifdef LSU_ALIGN_CHECK_EN
    do_cmd("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0,      32'h0,         1'b1, 1, 0);
    do_cmd("sh_mis", 1'b1, 3'b001, 32'h101, 32'h1234,   32'h0,         1'b1, 1, 0);
    do_cmd("f3_bad", 1'b0, 3'b111, 32'h100, 32'h0,      32'h0,         1'b1, 1, 0);
`else
    do_cmd("lw_mis", 1'b0, 3'b010, 32'h102, 32'h0,      32'h0000_8000, 1'b0, 3, 0);
`endif
    do_cmd("stall", 1'b0, 3'b010, 32'h100, 32'h0,       32'h0000_8000, 1'b0, 3, 5);
    // The bogus request offered during the stall must not have stored anything.
    do_cmd("post_stall", 1'b0, 3'b010, 32'h200, 32'h0,  32'h0,         1'b0, 3, 0);

    // Reset asserted while a load sits in CAPTURE.
    req_valid = 1'b1; req_write = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h100; req_wdata = 32'h0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk_reset_outputs("mid_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    do_cmd("sw2", 1'b1, 3'b010, 32'h104, 32'hCAFE_F00D, 32'h0,         1'b0, 2, 0);
    do_cmd("lw2", 1'b0, 3'b010, 32'h104, 32'h0,         32'hCAFE_F00D, 1'b0, 3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
